// File: rtl/rgmii_rx_frame_sched_pkg.sv
// Shared types and constants for the RGMII RX FIFO read scheduler.
// The FIFO word is {data_enable, data[7:0]}.
package rgmii_rx_frame_sched_pkg;

   localparam int FIFO_W = 9;
   localparam int EN_BIT = 8;

   typedef enum logic [1:0] {
      HOLDOFF,
      FILL,
      STREAM
   } sched_state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic       err;
   } rx_beat_t;

endpackage

// File: rtl/rgmii_rx_frame_sched_if.sv
// FIFO read port plus framed byte stream between the CDC FIFO, the scheduler and the MAC parser.
// The master modport is the scheduler side.
interface rgmii_rx_frame_sched_if;
   import rgmii_rx_frame_sched_pkg::*;

   logic [FIFO_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_prog_empty;
   logic              fifo_rd_en;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_sof;
   logic              out_eof;
   logic              out_err;

   modport master (
      input  fifo_dout, fifo_empty, fifo_prog_empty,
      output fifo_rd_en, out_valid, out_data, out_sof, out_eof, out_err
   );

   modport slave (
      output fifo_dout, fifo_empty, fifo_prog_empty,
      input  fifo_rd_en, out_valid, out_data, out_sof, out_eof, out_err
   );

endinterface

// File: rtl/rgmii_rx_frame_sched_delineator.sv
// Captures FIFO words, holds one byte of lookahead and emits sof/eof/err framing.
// Aborts on underrun or oversize, then discards the frame's tail until data_enable drops.
module rgmii_rx_frame_sched_delineator
   import rgmii_rx_frame_sched_pkg::*;
#(
   parameter int MAX_FRAME = 1522,
   parameter int LEN_W     = 11
) (
   input  logic              clk125MHz,
   input  logic              rst,
   input  logic              i_cap,
   input  logic [FIFO_W-1:0] i_word,
   input  logic              i_fifo_empty,
   output logic              o_in_frame,
   output logic              o_underrun,
   output logic              o_good_eof,
   output logic              o_abort,
   output logic              o_valid,
   output rx_beat_t          o_beat
);

   logic             w_en;
   logic [7:0]       w_data;
   logic             w_at_max;
   logic             w_underrun;
   logic             w_emit, w_eof, w_err;
   logic             w_start, w_shift, w_close, w_set_disc, w_clr_disc;
   rx_beat_t         w_beat;

   logic             r_in_frame;
   logic             r_discard;
   logic             r_pend_sof;
   logic [7:0]       r_pend_data;
   logic [LEN_W-1:0] r_len;
   logic             r_out_valid;
   rx_beat_t         r_out;

   assign w_en       = i_word[EN_BIT];
   assign w_data     = i_word[7:0];
   assign w_at_max   = (r_len == LEN_W'(MAX_FRAME));
   assign w_underrun = r_in_frame && i_fifo_empty && !i_cap;

   // A pending byte at MAX_FRAME is only an overrun if another frame byte follows it.
   always_comb begin
      w_emit     = 1'b0;
      w_eof      = 1'b0;
      w_err      = 1'b0;
      w_start    = 1'b0;
      w_shift    = 1'b0;
      w_close    = 1'b0;
      w_set_disc = 1'b0;
      w_clr_disc = 1'b0;
      if (i_cap) begin
         if (!w_en) begin
            w_clr_disc = 1'b1;
            if (r_in_frame) begin
               w_emit  = 1'b1;
               w_eof   = 1'b1;
               w_close = 1'b1;
            end
         end else if (r_in_frame) begin
            w_emit = 1'b1;
            if (w_at_max) begin
               w_eof      = 1'b1;
               w_err      = 1'b1;
               w_close    = 1'b1;
               w_set_disc = 1'b1;
            end else begin
               w_shift = 1'b1;
            end
         end else if (!r_discard) begin
            w_start = 1'b1;
         end
      end else if (w_underrun) begin
         w_emit     = 1'b1;
         w_eof      = 1'b1;
         w_err      = 1'b1;
         w_close    = 1'b1;
         w_set_disc = 1'b1;
      end
   end

   always_comb begin
      w_beat      = '0;
      w_beat.data = r_pend_data;
      w_beat.sof  = r_pend_sof;
      w_beat.eof  = w_eof;
      w_beat.err  = w_err;
   end

   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         r_in_frame  <= 1'b0;
         r_discard   <= 1'b0;
         r_pend_sof  <= 1'b0;
         r_pend_data <= '0;
         r_len       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         r_out_valid <= w_emit;
         r_out       <= w_emit ? w_beat : '0;
         if (w_start || w_shift) begin
            r_pend_data <= w_data;
            r_pend_sof  <= w_start;
            r_len       <= w_start ? LEN_W'(1) : r_len + LEN_W'(1);
         end
         if (w_start) begin
            r_in_frame <= 1'b1;
         end else if (w_close) begin
            r_in_frame <= 1'b0;
         end
         if (w_set_disc) begin
            r_discard <= 1'b1;
         end else if (w_clr_disc) begin
            r_discard <= 1'b0;
         end
      end
   end

   assign o_in_frame = r_in_frame;
   assign o_underrun = w_underrun;
   assign o_good_eof = w_emit && w_eof && !w_err;
   assign o_abort    = w_emit && w_err;
   assign o_valid    = r_out_valid;
   assign o_beat     = r_out;

endmodule

// File: rtl/rgmii_rx_frame_sched.sv
// Read-side scheduler for the RGMII RX CDC FIFO: fill/hold-off hysteresis, framed byte output,
// good-frame and aborted-frame counters.
//
// state   | meaning
// HOLDOFF | rd_en low, counting out the re-arm delay after a drain stops
// FILL    | rd_en low, waiting for the FIFO to climb above prog_empty
// STREAM  | rd_en follows !fifo_empty; never left inside a frame except on underrun
module rgmii_rx_frame_sched
   import rgmii_rx_frame_sched_pkg::*;
#(
   parameter int HOLDOFF_CYC = 60,
   parameter int MAX_FRAME   = 1522,
   parameter int LEN_W       = 11
) (
   input  logic                          clk125MHz,
   input  logic                          rst,
   rgmii_rx_frame_sched_if.master        bus,
   output logic [15:0]                   frame_cnt,
   output logic [7:0]                    err_cnt
);

   localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

   sched_state_t      r_state, w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_rd_q;
   logic [15:0]       r_frame_cnt;
   logic [7:0]        r_err_cnt;

   logic              w_rd_en;
   logic              w_hold_done;
   logic              w_stop;
   logic              w_in_frame, w_underrun, w_good_eof, w_abort, w_out_valid;
   rx_beat_t          w_beat;

   assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLDOFF_CYC - 1));
   assign w_stop      = !w_in_frame && bus.fifo_prog_empty && !r_rd_q;

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      unique case (r_state)
         HOLDOFF: if (w_hold_done) w_state_nxt = FILL;
         FILL:    if (!bus.fifo_prog_empty) w_state_nxt = STREAM;
         STREAM: begin
            if (w_underrun || w_stop) begin
               w_state_nxt = HOLDOFF;
            end else begin
               w_rd_en = !bus.fifo_empty;
            end
         end
         default: w_state_nxt = HOLDOFF;
      endcase
   end

   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         r_state     <= HOLDOFF;
         r_hold_cnt  <= '0;
         r_rd_q      <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= (r_state == HOLDOFF && !w_hold_done) ? r_hold_cnt + HOLD_W'(1) : '0;
         r_rd_q     <= w_rd_en;
         if (w_good_eof) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_abort && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   rgmii_rx_frame_sched_delineator #(
      .MAX_FRAME (MAX_FRAME),
      .LEN_W     (LEN_W)
   ) u_delin (
      .clk125MHz    (clk125MHz),
      .rst          (rst),
      .i_cap        (r_rd_q),
      .i_word       (bus.fifo_dout),
      .i_fifo_empty (bus.fifo_empty),
      .o_in_frame   (w_in_frame),
      .o_underrun   (w_underrun),
      .o_good_eof   (w_good_eof),
      .o_abort      (w_abort),
      .o_valid      (w_out_valid),
      .o_beat       (w_beat)
   );

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_data   = w_beat.data;
   assign bus.out_sof    = w_beat.sof;
   assign bus.out_eof    = w_beat.eof;
   assign bus.out_err    = w_beat.err;
   assign frame_cnt      = r_frame_cnt;
   assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_rgmii_rx_frame_sched.sv
// Scoreboard bench: stimulus pushes FIFO words and expected beats, a monitor pops and compares.
module tb_rgmii_rx_frame_sched;
   import rgmii_rx_frame_sched_pkg::*;

   localparam int PE_TH = 8;

   logic        clk125MHz = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   rgmii_rx_frame_sched_if bus();

   rgmii_rx_frame_sched #(
      .HOLDOFF_CYC (60),
      .MAX_FRAME   (1522),
      .LEN_W       (11)
   ) dut (
      .clk125MHz (clk125MHz),
      .rst       (rst),
      .bus       (bus),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk125MHz = ~clk125MHz;

   logic [8:0] fifo_q[$];
   rx_beat_t   exp_q[$];
   rx_beat_t   mon_e;
   int         n_chk = 0;
   int         n_pass = 0;
   int         n_out = 0;

   // Standard (non-FWFT) FIFO: dout updates the edge after rd_en, flags are registered.
   always @(posedge clk125MHz) begin
      if (rst) begin
         bus.fifo_dout <= '0;
      end else if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
         bus.fifo_dout <= fifo_q.pop_front();
      end
      bus.fifo_empty      <= (fifo_q.size() == 0);
      bus.fifo_prog_empty <= (fifo_q.size() < PE_TH);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   always @(negedge clk125MHz) begin
      if (!rst) begin
         if (bus.out_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL out_unexpected: got data 0x%0h sof %0b eof %0b err %0b, expected no beat at %0t",
                        bus.out_data, bus.out_sof, bus.out_eof, bus.out_err, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_beat", {21'd0, bus.out_data, bus.out_sof, bus.out_eof, bus.out_err},
                     {21'd0, mon_e});
            end
         end else begin
            check("idle_flags", {29'd0, bus.out_sof, bus.out_eof, bus.out_err}, 32'd0);
         end
      end
   end

   task automatic push_bytes(input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) fifo_q.push_back({1'b1, seed + 8'(i)});
   endtask

   task automatic push_idle(input int n);
      repeat (n) fifo_q.push_back(9'h000);
   endtask

   task automatic expect_bytes(input int n, input logic [7:0] seed, input bit last_err);
      rx_beat_t e;
      for (int i = 0; i < n; i++) begin
         e.data = seed + 8'(i);
         e.sof  = (i == 0);
         e.eof  = (i == n - 1);
         e.err  = last_err && (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
         @(posedge clk125MHz);
         #2;
         n++;
      end
      check({name, "_drain"}, 32'(n < budget), 32'd1);
      repeat (4) @(posedge clk125MHz);
      #2;
   endtask

   task automatic measure_rd_en_rise(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk125MHz);
         #1;
         n++;
      end while (bus.fifo_rd_en !== 1'b1 && n < 200);
      check(name, 32'(n), 32'd61);
   endtask

   initial begin
      int n;
      int base;
      int rd_seen;

      // 64-byte frame plus 12 idle words waiting in the FIFO before reset is released
      push_bytes(64, 8'h00);
      push_idle(12);
      expect_bytes(64, 8'h00, 1'b0);
      repeat (3) @(posedge clk125MHz);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      #1 rst = 1'b0;
      measure_rd_en_rise("rd_en_rise_after_rst");
      wait_drain("frame64", 1000);
      check("frame64_frame_cnt", 32'(frame_cnt), 32'd1);
      check("frame64_err_cnt", 32'(err_cnt), 32'd0);

      // underrun after 10 bytes of a 64-byte frame
      push_bytes(10, 8'h20);
      expect_bytes(10, 8'h20, 1'b1);
      wait_drain("underrun", 1000);
      check("underrun_err_cnt", 32'(err_cnt), 32'd1);
      check("underrun_frame_cnt", 32'(frame_cnt), 32'd1);
      push_bytes(54, 8'h2A);
      push_idle(12);
      rd_seen = 0;
      repeat (40) begin
         @(posedge clk125MHz);
         #1;
         if (bus.fifo_rd_en === 1'b1) rd_seen++;
      end
      check("holdoff_after_underrun", 32'(rd_seen), 32'd0);
      #1;
      wait_drain("underrun_tail", 1000);
      check("tail_err_cnt", 32'(err_cnt), 32'd1);
      check("tail_frame_cnt", 32'(frame_cnt), 32'd1);

      // back-to-back single-byte frames
      push_idle(4);
      fifo_q.push_back({1'b1, 8'hA5});
      push_idle(1);
      fifo_q.push_back({1'b1, 8'h5A});
      push_idle(4);
      expect_bytes(1, 8'hA5, 1'b0);
      expect_bytes(1, 8'h5A, 1'b0);
      wait_drain("singles", 1000);
      check("singles_frame_cnt", 32'(frame_cnt), 32'd3);
      check("singles_err_cnt", 32'(err_cnt), 32'd1);

      // 1600-byte frame truncated at byte 1521
      push_bytes(1600, 8'h40);
      push_idle(8);
      expect_bytes(1522, 8'h40, 1'b1);
      wait_drain("oversize", 6000);
      check("oversize_err_cnt", 32'(err_cnt), 32'd2);
      check("oversize_frame_cnt", 32'(frame_cnt), 32'd3);

      // reset asserted once byte 30 of a frame has been delivered
      base = n_out;
      push_bytes(64, 8'h80);
      push_idle(12);
      expect_bytes(64, 8'h80, 1'b0);
      n = 0;
      while (n_out < base + 31 && n < 500) begin
         @(posedge clk125MHz);
         #2;
         n++;
      end
      check("reach_byte30", 32'(n < 500), 32'd1);
      rst = 1'b1;
      @(posedge clk125MHz);
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("midrst_err_cnt", 32'(err_cnt), 32'd0);
      exp_q.delete();
      fifo_q.delete();
      push_bytes(16, 8'hC0);
      push_idle(4);
      expect_bytes(16, 8'hC0, 1'b0);
      repeat (3) @(posedge clk125MHz);
      #2 rst = 1'b0;
      measure_rd_en_rise("rd_en_rise_after_midrst");
      wait_drain("post_rst", 1000);
      check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
      check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
